// File: rtl/sid_bus_n.sv
// Multi-chip SID register bus front end: write-edge capture, per-chip register image, bus latch and model-select magic sequence.
// Optional build macro SID_BUS_DECAY_EN enables per-chip bus-latch decay after DECAY_CYCLES clocks.
module sid_bus_n #(
    parameter int unsigned N_SID        = 2,
    parameter int unsigned DECAY_CYCLES = 2000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           bus_addr,
    input  logic [N_SID-1:0]     bus_cs,
    input  logic                 bus_we,
    input  logic                 bus_oe,
    input  logic [7:0]           bus_data_i,
    output logic [7:0]           bus_data_o,
    input  logic [N_SID*32-1:0]  rd_i,
    output logic [N_SID*256-1:0] regs_o,
    output logic [N_SID-1:0]     model_o
);

    typedef enum logic [1:0] {
        IDLE,
        GOT_S,
        GOT_I
    } magic_t;

    if (N_SID < 1 || N_SID > 4) begin : g_bad_n_sid
        $error("sid_bus_n: N_SID must be 1..4");
    end
    if (DECAY_CYCLES < 2) begin : g_bad_decay
        $error("sid_bus_n: DECAY_CYCLES must be >= 2");
    end

    logic             we_q;
    logic             wr_stb;
    logic             rd_stb;
    logic             rd_any;
    logic             rd_live;
    logic [N_SID-1:0] sel_oh;
    logic [31:0]      sel_rd;
    logic [7:0]       sel_latch;
    logic [7:0]       rd_byte;
    logic [N_SID-1:0] latch_ld;
    logic [7:0]       latch_val;
    logic [N_SID-1:0] model_ld;

    logic [7:0] regs  [N_SID][32];
    logic [7:0] latch [N_SID];
    magic_t     state    [N_SID];
    magic_t     state_nx [N_SID];

    assign wr_stb = bus_we & ~we_q;
    assign rd_stb = bus_oe & ~bus_we & rd_any;
    assign rd_live = (bus_addr >= 5'h19) && (bus_addr <= 5'h1C);

    // Lowest-index selected chip wins a read
    always_comb begin
        rd_any    = 1'b0;
        sel_oh    = '0;
        sel_rd    = '0;
        sel_latch = '0;
        for (int unsigned k = 0; k < N_SID; k++) begin
            if (bus_cs[k] && !rd_any) begin
                rd_any    = 1'b1;
                sel_oh[k] = 1'b1;
                sel_rd    = rd_i[32*k +: 32];
                sel_latch = latch[k];
            end
        end
    end

    always_comb begin
        case (bus_addr)
            5'h19:   rd_byte = sel_rd[31:24];
            5'h1A:   rd_byte = sel_rd[23:16];
            5'h1B:   rd_byte = sel_rd[15:8];
            5'h1C:   rd_byte = sel_rd[7:0];
            default: rd_byte = sel_latch;
        endcase
    end

    always_comb begin
        latch_val = wr_stb ? bus_data_i : rd_byte;
        for (int unsigned k = 0; k < N_SID; k++) begin
            latch_ld[k] = (wr_stb && bus_cs[k]) || (rd_stb && sel_oh[k] && rd_live);
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < N_SID; k++) begin
            state_nx[k] = state[k];
            model_ld[k] = 1'b0;
            if (wr_stb && bus_cs[k]) begin
                if (bus_addr == 5'h1D && bus_data_i == 8'h53) begin
                    state_nx[k] = GOT_S;
                end else if (state[k] == GOT_S && bus_addr == 5'h1E && bus_data_i == 8'h49) begin
                    state_nx[k] = GOT_I;
                end else begin
                    state_nx[k] = IDLE;
                    model_ld[k] = (state[k] == GOT_I) && (bus_addr == 5'h1F);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            bus_data_o <= '0;
            model_o    <= '0;
            for (int unsigned k = 0; k < N_SID; k++) begin
                state[k] <= IDLE;
                for (int unsigned a = 0; a < 32; a++) begin
                    regs[k][a] <= '0;
                end
            end
        end else begin
            we_q <= bus_we;
            if (rd_stb) begin
                bus_data_o <= rd_byte;
            end
            for (int unsigned k = 0; k < N_SID; k++) begin
                state[k] <= state_nx[k];
                if (model_ld[k]) begin
                    model_o[k] <= bus_data_i[0];
                end
                if (wr_stb && bus_cs[k]) begin
                    regs[k][bus_addr] <= bus_data_i;
                end
            end
        end
    end

`ifdef SID_BUS_DECAY_EN
    logic [31:0] decay [N_SID];

    // A load always restarts the countdown; the latch clears on the 1 -> 0 step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N_SID; k++) begin
                latch[k] <= '0;
                decay[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < N_SID; k++) begin
                if (latch_ld[k]) begin
                    latch[k] <= latch_val;
                    decay[k] <= 32'(DECAY_CYCLES);
                end else if (decay[k] == 32'd1) begin
                    latch[k] <= '0;
                    decay[k] <= '0;
                end else if (decay[k] != '0) begin
                    decay[k] <= decay[k] - 32'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N_SID; k++) begin
                latch[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < N_SID; k++) begin
                if (latch_ld[k]) begin
                    latch[k] <= latch_val;
                end
            end
        end
    end
`endif

    // Byte 0x00 sits in the MSB byte of each chip slice
    always_comb begin
        regs_o = '0;
        for (int unsigned k = 0; k < N_SID; k++) begin
            for (int unsigned a = 0; a < 32; a++) begin
                regs_o[256*k + 255 - 8*a -: 8] = regs[k][a];
            end
        end
    end

endmodule

// File: tb/tb_sid_bus_n.sv
// Directed bench for sid_bus_n with a scoreboard queue of expected bytes.
// Decay expectations follow SID_BUS_DECAY_EN when the bench is built with it.
module tb_sid_bus_n;

    localparam int unsigned NS = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [4:0]       bus_addr = '0;
    logic [NS-1:0]    bus_cs = '0;
    logic             bus_we = 1'b0;
    logic             bus_oe = 1'b0;
    logic [7:0]       bus_data_i = '0;
    logic [7:0]       bus_data_o;
    logic [NS*32-1:0] rd_i = '0;
    logic [NS*256-1:0] regs_o;
    logic [NS-1:0]    model_o;

    sid_bus_n #(.N_SID(NS), .DECAY_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_addr   (bus_addr),
        .bus_cs     (bus_cs),
        .bus_we     (bus_we),
        .bus_oe     (bus_oe),
        .bus_data_i (bus_data_i),
        .bus_data_o (bus_data_o),
        .rd_i       (rd_i),
        .regs_o     (regs_o),
        .model_o    (model_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int unsigned kind;   // 0 bus_data_o, 1 register byte, 2 model bit
        int unsigned chip;
        int unsigned addr;
        logic [7:0]  exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [7:0] reg_byte(int unsigned k, int unsigned a);
        return regs_o[256*k + 255 - 8*a -: 8];
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %02h want %02h", tag, obs, exp);
        end
    endtask

    task automatic push(string tag, int unsigned kind, int unsigned chip, int unsigned addr, logic [7:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.chip = chip;
        e.addr = addr;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [7:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0:       obs = bus_data_o;
                1:       obs = reg_byte(e.chip, e.addr);
                default: obs = {7'b0, model_o[e.chip]};
            endcase
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int unsigned n);
        for (int unsigned i = 0; i < n; i++) cyc();
    endtask

    // Write edge lands on the first clock; a low cycle follows so the next write sees a fresh edge
    task automatic wr(logic [NS-1:0] cs, logic [4:0] addr, logic [7:0] data);
        bus_cs     = cs;
        bus_addr   = addr;
        bus_data_i = data;
        bus_we     = 1'b1;
        cyc();
        bus_we = 1'b0;
        bus_cs = '0;
        drain();
        cyc();
    endtask

    task automatic rd(logic [NS-1:0] cs, logic [4:0] addr, string tag, logic [7:0] exp);
        bus_cs   = cs;
        bus_addr = addr;
        bus_oe   = 1'b1;
        push(tag, 0, 0, 0, exp);
        cyc();
        bus_oe = 1'b0;
        bus_cs = '0;
        drain();
    endtask

    initial begin
        logic [7:0] decay_exp;

        // reset state
        rst_n = 1'b0;
        idle(3);
        chk("rst_data", bus_data_o, 8'h00);
        chk("rst_regs", {7'b0, |regs_o}, 8'h00);
        chk("rst_model", {6'b0, model_o}, 8'h00);
        rst_n = 1'b1;
        cyc();

        // single write to chip0 only
        push("wr_c0_b4", 1, 0, 4, 8'hA5);
        push("wr_c1_b4", 1, 1, 4, 8'h00);
        wr(2'b01, 5'h04, 8'hA5);

        // held bus_we writes only once, even if address/data move
        bus_cs = 2'b01; bus_addr = 5'h05; bus_data_i = 8'h11; bus_we = 1'b1;
        cyc();
        bus_data_i = 8'h22; bus_addr = 5'h06;
        idle(4);
        bus_we = 1'b0; bus_cs = '0;
        cyc();
        chk("held_b5", reg_byte(0, 5), 8'h11);
        chk("held_b6", reg_byte(0, 6), 8'h00);

        // live reads and bus latch
        rd_i = {8'h10, 8'h20, 8'h7E, 8'h40, 8'h01, 8'h02, 8'h03, 8'h04};
        rd(2'b10, 5'h1B, "rd_osc3_c1", 8'h7E);
        rd(2'b10, 5'h00, "rd_latch_c1", 8'h7E);
        rd(2'b01, 5'h00, "rd_latch_c0_wr", 8'h11);
        rd(2'b11, 5'h19, "rd_both_potx", 8'h01);
        rd(2'b10, 5'h03, "rd_latch_c1_kept", 8'h7E);
        rd(2'b01, 5'h02, "rd_latch_c0_potx", 8'h01);
        rd(2'b10, 5'h1C, "rd_env3_c1", 8'h40);

        // no read active: output holds
        bus_cs = 2'b01; bus_addr = 5'h1A;
        idle(2);
        bus_cs = '0;
        chk("hold_idle", bus_data_o, 8'h40);

        // we and oe together is a write only
        bus_cs = 2'b01; bus_addr = 5'h1A; bus_data_i = 8'h99; bus_we = 1'b1; bus_oe = 1'b1;
        cyc();
        bus_we = 1'b0; bus_oe = 1'b0; bus_cs = '0;
        chk("we_oe_data", bus_data_o, 8'h40);
        chk("we_oe_reg", reg_byte(0, 5'h1A), 8'h99);
        cyc();
        rd(2'b01, 5'h07, "we_oe_latch", 8'h99);

        // magic sequence broken by an intervening write
        wr(2'b01, 5'h1D, 8'h53);
        wr(2'b01, 5'h00, 8'h12);
        wr(2'b01, 5'h1E, 8'h49);
        push("magic_broken", 2, 0, 0, 8'h00);
        wr(2'b01, 5'h1F, 8'h01);

        // clean sequence
        wr(2'b01, 5'h1D, 8'h53);
        wr(2'b01, 5'h1E, 8'h49);
        push("magic_ok_m0", 2, 0, 0, 8'h01);
        push("magic_ok_m1", 2, 1, 0, 8'h00);
        push("magic_reg_1d", 1, 0, 5'h1D, 8'h53);
        push("magic_reg_1f", 1, 0, 5'h1F, 8'h01);
        wr(2'b01, 5'h1F, 8'h01);

        // repeated 0x53 restarts; bit0 of 0xFE loads 0
        wr(2'b01, 5'h1D, 8'h53);
        wr(2'b01, 5'h1D, 8'h53);
        wr(2'b01, 5'h1E, 8'h49);
        push("magic_restart", 2, 0, 0, 8'h00);
        wr(2'b01, 5'h1F, 8'hFE);

        wr(2'b01, 5'h1D, 8'h53);
        wr(2'b01, 5'h1E, 8'h49);
        push("magic_again", 2, 0, 0, 8'h01);
        wr(2'b01, 5'h1F, 8'h01);

        // latch decay timing
`ifdef SID_BUS_DECAY_EN
        decay_exp = 8'h00;
`else
        decay_exp = 8'h3C;
`endif
        wr(2'b01, 5'h00, 8'h3C);
        idle(8);
        rd(2'b01, 5'h00, "decay_10", 8'h3C);
        wr(2'b01, 5'h00, 8'h3C);
        idle(15);
        rd(2'b01, 5'h00, "decay_17", decay_exp);

        // broadcast write
        push("bcast_c0", 1, 0, 5'h18, 8'h0F);
        push("bcast_c1", 1, 1, 5'h18, 8'h0F);
        wr(2'b11, 5'h18, 8'h0F);

        // reset mid-sequence at GOT_I on chip1, bus_we already high across reset
        rd_i = '0;
        rd(2'b10, 5'h1B, "pre_rst_rd", 8'h00);
        rd(2'b01, 5'h00, "pre_rst_latch", 8'h0F);
        wr(2'b10, 5'h1D, 8'h53);
        wr(2'b10, 5'h1E, 8'h49);
        bus_cs = 2'b01; bus_addr = 5'h02; bus_data_i = 8'h5A; bus_we = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst2_data", bus_data_o, 8'h00);
        chk("rst2_regs", {7'b0, |regs_o}, 8'h00);
        chk("rst2_model", {6'b0, model_o}, 8'h00);
        rst_n = 1'b1;
        cyc();
        bus_we = 1'b0; bus_cs = '0;
        chk("rst2_first_wr", reg_byte(0, 2), 8'h5A);
        cyc();
        rd(2'b10, 5'h00, "rst2_latch_c1", 8'h00);
        push("rst2_fsm_idle", 2, 1, 0, 8'h00);
        push("rst2_reg_1f", 1, 1, 5'h1F, 8'h01);
        wr(2'b10, 5'h1F, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
